// File: rtl/tone_voice_bank_pkg.sv
// Shared types and constants for the tone voice bank: waveform codes, register
// select values, config-word field positions and the base note pitch table.
package tone_pkg;

  typedef enum logic [1:0] {
    WAVE_TRI    = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_HOLD   = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

  localparam logic SEL_PHASE  = 1'b0;
  localparam logic SEL_CONFIG = 1'b1;

  localparam int CFG_ENABLE_BIT = 11;
  localparam int CFG_WAVE_LSB   = 8;
  localparam int CFG_OCTAVE_LSB = 3;
  localparam int CFG_NOTE_LSB   = 0;
  localparam int NOTE_BITS      = 3;

  function automatic logic [14:0] note_delta0(input logic [NOTE_BITS-1:0] note);
    logic [14:0] d;
    case (note)
      3'd0:    d = 15'h4000;
      3'd1:    d = 15'h6000;
      3'd2:    d = 15'h5000;
      3'd3:    d = 15'h4800;
      3'd4:    d = 15'h7800;
      3'd5:    d = 15'h6C00;
      3'd6:    d = 15'h5A00;
      default: d = 15'h5555;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tone_voice_bank_phase_step.sv
// Combinational next-phase for one voice; shared by all voices through the top's voice mux.
// Triangle folds before the top two phase bits reach 11 (rising) or 00 (falling); hold never updates.
module tone_phase_step
  import tone_pkg::*;
#(
  parameter int PHASE_BITS = 16
) (
  input  logic [PHASE_BITS-1:0] phase,
  input  logic                  dir,
  input  logic [PHASE_BITS-1:0] delta,
  input  wave_t                 wave,
  output logic [PHASE_BITS-1:0] next_phase,
  output logic                  next_dir,
  output logic                  update
);

  logic [PHASE_BITS-1:0] sum;
  logic [PHASE_BITS-1:0] diff;

  assign sum  = phase + delta;
  assign diff = phase - delta;

  // dir: 0 = rising, 1 = falling; a fold keeps the phase and only turns around
  always_comb begin
    next_phase = phase;
    next_dir   = dir;
    update     = 1'b1;
    case (wave)
      WAVE_TRI: begin
        if (!dir) begin
          if (sum[PHASE_BITS-1 -: 2] == 2'b11) next_dir = 1'b1;
          else                                 next_phase = sum;
        end else begin
          if (diff[PHASE_BITS-1 -: 2] == 2'b00) next_dir = 1'b0;
          else                                  next_phase = diff;
        end
      end
      WAVE_SAW, WAVE_SQUARE: next_phase = sum;
      default:               update = 1'b0;
    endcase
  end

endmodule

// File: rtl/tone_voice_bank.sv
// Multi-voice tone generator: one phase adder walks the voices per sample_req and sums them.
// Latency req -> sample_valid is NUM_VOICES+1 cycles; one request is queued while busy, more are dropped.
module tone_voice_bank
  import tone_pkg::*;
#(
  parameter  int NUM_VOICES  = 4,
  parameter  int PHASE_BITS  = 16,
  parameter  int OCTAVE_BITS = 4,
  localparam int VOICE_BITS  = $clog2(NUM_VOICES),
  localparam int OUT_BITS    = PHASE_BITS + VOICE_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_we,
  input  logic [VOICE_BITS:0]   reg_addr,
  input  logic [15:0]           reg_wdata,
  input  logic                  sample_req,
  output logic [OUT_BITS-1:0]   sample_out,
  output logic                  sample_valid,
  output logic                  busy
);

  logic [PHASE_BITS-1:0]  phase_q [NUM_VOICES];
  logic                   dir_q   [NUM_VOICES];
  logic                   en_q    [NUM_VOICES];
  wave_t                  wave_q  [NUM_VOICES];
  logic [OCTAVE_BITS-1:0] oct_q   [NUM_VOICES];
  logic [NOTE_BITS-1:0]   note_q  [NUM_VOICES];

  seq_state_t            state_q, state_d;
  logic [VOICE_BITS-1:0] voice_q;
  logic [OUT_BITS-1:0]   acc_q;
  logic                  pending_q;
  logic                  start, run, last_voice;

  logic [VOICE_BITS-1:0] wr_voice;
  logic                  wr_sel;
  logic [15:0]           delta_full;
  logic [PHASE_BITS-1:0] cur_phase, cur_delta, contrib, step_phase;
  logic                  step_dir, step_update;
  logic [OUT_BITS-1:0]   acc_sum;

  assign wr_voice   = reg_addr[VOICE_BITS:1];
  assign wr_sel     = reg_addr[0];
  assign last_voice = (voice_q == VOICE_BITS'(NUM_VOICES - 1));

  assign cur_phase  = phase_q[voice_q];
  assign delta_full = {1'b0, note_delta0(note_q[voice_q])} >> ~oct_q[voice_q];
  assign cur_delta  = PHASE_BITS'(delta_full);

  always_comb begin
    contrib = '0;
    if (en_q[voice_q]) begin
      if (wave_q[voice_q] == WAVE_SQUARE) contrib = {PHASE_BITS{cur_phase[PHASE_BITS-1]}};
      else                                contrib = cur_phase;
    end
  end

  assign acc_sum = acc_q + OUT_BITS'(contrib);

  tone_phase_step #(.PHASE_BITS(PHASE_BITS)) u_step (
    .phase      (cur_phase),
    .dir        (dir_q[voice_q]),
    .delta      (cur_delta),
    .wave       (wave_q[voice_q]),
    .next_phase (step_phase),
    .next_dir   (step_dir),
    .update     (step_update)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE: if (sample_req || pending_q) state_d = SEQ_RUN;
      SEQ_RUN:  if (last_voice) state_d = SEQ_DONE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  // busy also covers IDLE with a queued request, which restarts on the next edge
  always_comb begin
    sample_valid = 1'b0;
    busy         = pending_q;
    start        = 1'b0;
    run          = 1'b0;
    case (state_q)
      SEQ_IDLE: start = sample_req || pending_q;
      SEQ_RUN:  begin run = 1'b1; busy = 1'b1; end
      SEQ_DONE: begin sample_valid = 1'b1; busy = 1'b1; end
      default:  ;
    endcase
  end

  // sample_out is loaded with the final sum on entry to DONE so it is stable while sample_valid is high
  always_ff @(posedge clk) begin
    if (reset) begin
      voice_q    <= '0;
      acc_q      <= '0;
      pending_q  <= 1'b0;
      sample_out <= '0;
    end else begin
      if (sample_req && busy) pending_q <= 1'b1;
      else if (start)         pending_q <= 1'b0;
      if (start) begin
        voice_q <= '0;
        acc_q   <= '0;
      end else if (run) begin
        voice_q <= voice_q + 1'b1;
        acc_q   <= acc_sum;
        if (last_voice) sample_out <= acc_sum;
      end
    end
  end

  // A register write to the voice in its slot wins and suppresses that voice's phase step
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (reset) begin
        phase_q[i] <= {1'b1, {(PHASE_BITS-1){1'b0}}};
        dir_q[i]   <= 1'b0;
        en_q[i]    <= 1'b0;
        wave_q[i]  <= WAVE_TRI;
        oct_q[i]   <= '0;
        note_q[i]  <= '0;
      end else if (reg_we && wr_voice == VOICE_BITS'(i)) begin
        if (wr_sel == SEL_PHASE) begin
          phase_q[i] <= PHASE_BITS'(reg_wdata);
        end else begin
          en_q[i]   <= reg_wdata[CFG_ENABLE_BIT];
          wave_q[i] <= wave_t'(reg_wdata[CFG_WAVE_LSB +: 2]);
          oct_q[i]  <= reg_wdata[CFG_OCTAVE_LSB +: OCTAVE_BITS];
          note_q[i] <= reg_wdata[CFG_NOTE_LSB +: NOTE_BITS];
        end
      end else if (run && voice_q == VOICE_BITS'(i) && en_q[i] && step_update) begin
        phase_q[i] <= step_phase;
        dir_q[i]   <= step_dir;
      end
    end
  end

endmodule

// File: tb/tb_tone_voice_bank.sv
// Directed bench for tone_voice_bank with hand-computed sample values and latencies.
module tb_tone_voice_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        sample_req;
  logic [17:0] sample_out;
  logic        sample_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_voice_bank dut (
    .clk          (clk),
    .reset        (reset),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .sample_req   (sample_req),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic reg_write(input int voice, input logic sel, input logic [15:0] d);
    reg_we    = 1'b1;
    reg_addr  = {voice[1:0], sel};
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
  endtask

  task automatic wait_valid(output logic [17:0] val, output int lat);
    val = '0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        lat = c;
        val = sample_out;
      end
      tick();
      sample_req = 1'b0;
      if (lat >= 0) break;
    end
  endtask

  task automatic request(input string tag, input logic [17:0] exp);
    logic [17:0] v;
    int          l;
    sample_req = 1'b1;
    wait_valid(v, l);
    check({tag, "_lat"}, l, 5);
    check(tag, {14'd0, v}, {14'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] v;
    int          l;
    int          vcount, v1, v2, busy_drop;

    reset      = 1'b1;
    reg_we     = 1'b0;
    reg_addr   = '0;
    reg_wdata  = '0;
    sample_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_sample_out", {14'd0, sample_out}, 32'h0);
    check("rst_valid", {31'd0, sample_valid}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    tick();

    // all voices disabled
    request("t1_all_off", 18'h0);

    // triangle on voice 0: contributions are the pre-step phases
    reg_write(0, 1'b1, 16'h0878);
    request("t2_s1", 18'h08000);
    request("t2_s2", 18'h08000);
    request("t2_s3", 18'h04000);
    request("t2_s4", 18'h04000);
    request("t2_s5", 18'h08000);

    // saw on voice 1 wraps through zero
    do_reset();
    reg_write(1, 1'b1, 16'h0978);
    request("t3_s1", 18'h08000);
    request("t3_s2", 18'h0C000);
    request("t3_s3", 18'h00000);
    request("t3_s4", 18'h04000);

    // four saws, then voice 2 as square
    do_reset();
    for (int i = 0; i < 4; i++) reg_write(i, 1'b1, 16'h0978);
    request("t4_sum4", 18'h20000);
    reg_write(2, 1'b1, 16'h0A78);
    request("t4_square_hi", 18'h33FFF);
    request("t4_square_lo", 18'h00000);

    // three back-to-back requests: one queued, one dropped
    do_reset();
    vcount = 0; v1 = -1; v2 = -1; busy_drop = 0;
    sample_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (sample_valid) begin
        vcount++;
        if (vcount == 1) v1 = c;
        else             v2 = c;
      end
      if (c >= 1 && c <= 11 && !busy) busy_drop++;
      tick();
      sample_req = (c < 2);
    end
    check("t5_pulses", vcount, 2);
    check("t5_first_at", v1, 5);
    check("t5_second_at", v2, 11);
    check("t5_busy_drop", busy_drop, 0);

    // reset while voice 2 is in its slot
    do_reset();
    for (int i = 0; i < 4; i++) reg_write(i, 1'b1, 16'h0978);
    request("t6_pre", 18'h20000);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("t6_busy_mid_run", {31'd0, busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_out_after_rst", {14'd0, sample_out}, 32'h0);
    check("t6_busy_after_rst", {31'd0, busy}, 32'h0);
    vcount = 0;
    for (int c = 0; c < 8; c++) begin
      if (sample_valid) vcount++;
      @(negedge clk);
    end
    check("t6_no_valid", vcount, 0);
    tick();
    for (int i = 0; i < 4; i++) reg_write(i, 1'b1, 16'h0978);
    request("t6_phases_reset", 18'h20000);

    // phase write to voice 0 during its own slot
    do_reset();
    reg_write(0, 1'b1, 16'h0978);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    reg_we     = 1'b1;
    reg_addr   = 3'b000;
    reg_wdata  = 16'h1234;
    tick();
    reg_we     = 1'b0;
    wait_valid(v, l);
    check("t7_prewrite_contrib", {14'd0, v}, 32'h08000);
    request("t7_written_phase", 18'h01234);
    request("t7_advanced", 18'h05234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
